decim_avg_iq_core: RTL and testbench

I/Q block-averaging decimator: reads `ilen` input samples per channel, averages each block of D = 2^k samples with round-half-up, and writes one decimated I/Q pair per block. It is the receive-side counterpart of the interpolation core and uses the same 128-bit config word, status byte, memory/FIFO port set and accelerator/streaming modes, so both cores drop into the same wrapper.

---
 rtl/decim_avg_iq_core.sv | 200 ++++++++++++++++++++
 tb/tb_decim_avg_iq_core.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decim_avg_iq_core.sv
// decim_avg_iq_core: I/Q block-averaging decimator.
// Reads ilen samples per channel (memory or input FIFO), averages each block
// of D = 2^k samples with round-half-up and writes one I/Q result per block.
// A trailing partial block is accumulated and then dropped.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   start                      begin a job (only honoured in IDLE)
//   Empty_i, Afull_i           input FIFO empty / output FIFO almost full
//   config_reg[127:0]          reg0[0]=bypass reg0[1]=mode(1=stream)
//                              reg1[7:0]=k reg2=ilen reg3 unused
//   data_from_mem_I/Q          memory read data (1 cycle after address)
//   data_from_fifo_I/Q         FIFO read data (1 cycle after read enable)
//   Read_addr_mem              input sample index (truncated rd count)
//   Write_addr_mem             output index (truncated out count)
//   Write_Enable_mem/_fifo     result write strobe, routed by mode
//   Read_Enable_fifo           FIFO pop in stream mode
//   status_reg[7:0]            {0,0,bypass,mode,stop_Afull,stop_empty,busy,done}
//   I_dec, Q_dec               registered averages

// Per-channel accumulate / round / shift.
module decim_avg_lane #(
  parameter int DW   = 12,
  parameter int ACCW = 16,
  parameter int KW   = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_clr,
  input  logic                 i_vld,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic [KW-1:0]        i_k,
  input  logic signed [DW-1:0] i_smp,
  output logic signed [DW-1:0] o_res
);
  logic signed [ACCW-1:0] r_acc, w_ext, w_acc_new, w_rnd, w_sum;

  always_comb begin
    w_ext     = {{(ACCW-DW){i_smp[DW-1]}}, i_smp};
    w_acc_new = i_first ? w_ext : r_acc + w_ext;
    // half an LSB of the output, so the arithmetic shift rounds half up
    w_rnd     = (i_k == '0) ? '0 : (ACCW'(1) << (i_k - 1'b1));
    w_sum     = w_acc_new + w_rnd;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc <= '0;
      o_res <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_vld) begin
      r_acc <= w_acc_new;
      // a block average always fits the sample range, so plain truncation
      if (i_last) o_res <= DW'(w_sum >>> i_k);
    end
  end
endmodule

module decim_avg_iq_core #(
  parameter int CONFIG_WIDTH   = 32,
  parameter int DATAPATH_WIDTH = 12,
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int LOG2_DMAX      = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic                             Empty_i,
  input  logic                             Afull_i,
  input  logic [4*CONFIG_WIDTH-1:0]        config_reg,
  input  logic signed [DATAPATH_WIDTH-1:0] data_from_mem_I,
  input  logic signed [DATAPATH_WIDTH-1:0] data_from_mem_Q,
  input  logic signed [DATAPATH_WIDTH-1:0] data_from_fifo_I,
  input  logic signed [DATAPATH_WIDTH-1:0] data_from_fifo_Q,
  output logic [MEM_ADDR_WIDTH-1:0]        Read_addr_mem,
  output logic [MEM_ADDR_WIDTH-1:0]        Write_addr_mem,
  output logic                             Write_Enable_mem,
  output logic                             Write_Enable_fifo,
  output logic                             Read_Enable_fifo,
  output logic [7:0]                       status_reg,
  output logic signed [DATAPATH_WIDTH-1:0] I_dec,
  output logic signed [DATAPATH_WIDTH-1:0] Q_dec
);
  localparam int DW   = DATAPATH_WIDTH;
  localparam int CW   = CONFIG_WIDTH;
  localparam int ACCW = DATAPATH_WIDTH + LOG2_DMAX;
  localparam int KW   = $clog2(LOG2_DMAX + 1);
  localparam int NUM_LANES = 2;  // lane 0 = I, lane 1 = Q

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic                  r_bypass, r_mode;
  logic [KW-1:0]         r_k, w_keff;
  logic [CW-1:0]         r_ilen, r_rd_cnt, r_out_cnt;
  logic [LOG2_DMAX-1:0]  r_smp_cnt, w_dm1;
  logic                  r_vld, r_wr;
  logic                  w_start_acc, w_rd, w_first, w_last, w_busy, w_done;
  logic [7:0]            w_kf;
  logic                  w_unused;
  logic [NUM_LANES-1:0][DW-1:0] w_smp, w_res;

  assign w_kf     = config_reg[CW +: 8];
  assign w_keff   = config_reg[0] ? '0 :
                    (w_kf > 8'(LOG2_DMAX)) ? KW'(LOG2_DMAX) : w_kf[KW-1:0];
  assign w_unused = &{1'b0, config_reg[4*CW-1:3*CW], config_reg[2*CW-1:CW+8],
                      config_reg[CW-1:2]};

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_dm1       = ~({LOG2_DMAX{1'b1}} << r_k);  // D-1
  assign w_first     = (r_smp_cnt == '0);
  assign w_last      = (r_smp_cnt == w_dm1);
  // Stream mode stalls on either flag, combinationally, in the same cycle.
  assign w_rd = (r_state == S_RUN) && (r_rd_cnt < r_ilen) &&
                (!r_mode || (!Empty_i && !Afull_i));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state: leave RUN once all reads are issued and the last sample has
  // been absorbed; a strobe raised this cycle completes this cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = (config_reg[3*CW-1:2*CW] == '0) ? S_DONE : S_RUN;
      S_RUN:  if ((r_rd_cnt == r_ilen) && !r_vld) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    w_busy            = (r_state == S_RUN);
    w_done            = (r_state == S_DONE);
    Read_addr_mem     = r_rd_cnt[MEM_ADDR_WIDTH-1:0];
    Write_addr_mem    = r_out_cnt[MEM_ADDR_WIDTH-1:0];
    Write_Enable_mem  = r_wr & ~r_mode;
    Write_Enable_fifo = r_wr & r_mode;
    Read_Enable_fifo  = w_rd & r_mode;
    status_reg        = {2'b00, r_bypass, r_mode, w_busy & r_mode & Afull_i,
                         w_busy & r_mode & Empty_i, w_busy, w_done};
  end

  // Counters and the read-valid / write-strobe pipeline
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bypass  <= 1'b0;
      r_mode    <= 1'b0;
      r_k       <= '0;
      r_ilen    <= '0;
      r_rd_cnt  <= '0;
      r_out_cnt <= '0;
      r_smp_cnt <= '0;
      r_vld     <= 1'b0;
      r_wr      <= 1'b0;
    end else if (w_start_acc) begin
      r_bypass  <= config_reg[0];
      r_mode    <= config_reg[1];
      r_k       <= w_keff;
      r_ilen    <= config_reg[3*CW-1:2*CW];
      r_rd_cnt  <= '0;
      r_out_cnt <= '0;
      r_smp_cnt <= '0;
      r_vld     <= 1'b0;
      r_wr      <= 1'b0;
    end else begin
      r_vld <= w_rd;
      r_wr  <= r_vld & w_last;
      if (w_rd) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (r_vld) r_smp_cnt <= w_last ? '0 : r_smp_cnt + 1'b1;
      if (r_wr) r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  assign w_smp[0] = r_mode ? data_from_fifo_I : data_from_mem_I;
  assign w_smp[1] = r_mode ? data_from_fifo_Q : data_from_mem_Q;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    decim_avg_lane #(.DW(DW), .ACCW(ACCW), .KW(KW)) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .i_clr   (w_start_acc),
      .i_vld   (r_vld),
      .i_first (w_first),
      .i_last  (w_last),
      .i_k     (r_k),
      .i_smp   (w_smp[g]),
      .o_res   (w_res[g])
    );
  end

  assign I_dec = w_res[0];
  assign Q_dec = w_res[1];
endmodule

// File: tb/tb_decim_avg_iq_core.sv
module tb_decim_avg_iq_core;
  localparam int DW = 12;
  localparam int MAW = 16;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, Empty_i = 1'b0, Afull_i = 1'b0;
  logic [127:0] config_reg = '0;
  logic signed [DW-1:0] dmI = '0, dmQ = '0, dfI = '0, dfQ = '0;
  logic [MAW-1:0] ra, wa;
  logic wem, wef, ren;
  logic [7:0] st;
  logic signed [DW-1:0] idec, qdec;

  decim_avg_iq_core dut (
    .clk(clk), .rstn(rstn), .start(start), .Empty_i(Empty_i), .Afull_i(Afull_i),
    .config_reg(config_reg),
    .data_from_mem_I(dmI), .data_from_mem_Q(dmQ),
    .data_from_fifo_I(dfI), .data_from_fifo_Q(dfQ),
    .Read_addr_mem(ra), .Write_addr_mem(wa),
    .Write_Enable_mem(wem), .Write_Enable_fifo(wef), .Read_Enable_fifo(ren),
    .status_reg(st), .I_dec(idec), .Q_dec(qdec)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic signed [DW-1:0] memI [0:255];
  logic signed [DW-1:0] memQ [0:255];
  int fptr = 0;
  int expI[$], expQ[$], gotI[$], gotQ[$], gotA[$];

  // Memory returns data one cycle after the address; FIFO one cycle after pop.
  always @(posedge clk) begin
    dmI <= memI[ra[7:0]];
    dmQ <= memQ[ra[7:0]];
    if (start) fptr <= 0;
    else if (ren) begin
      dfI  <= memI[fptr[7:0]];
      dfQ  <= memQ[fptr[7:0]];
      fptr <= fptr + 1;
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fdiv(input int s, input int d);
    return (s >= 0) ? s / d : -((-s + d - 1) / d);
  endfunction

  // Reference: average each complete block of D samples, round half up.
  task automatic model(input int n, input int k);
    int d, half, si, sq;
    d = 1 << k;
    half = (k > 0) ? d / 2 : 0;
    expI.delete(); expQ.delete();
    for (int b = 0; b < n / d; b++) begin
      si = 0; sq = 0;
      for (int j = 0; j < d; j++) begin
        si += int'(memI[b*d+j]);
        sq += int'(memQ[b*d+j]);
      end
      expI.push_back(fdiv(si + half, d));
      expQ.push_back(fdiv(sq + half, d));
    end
  endtask

  task automatic load_rand(input int n);
    for (int i = 0; i < n; i++) begin
      memI[i] = 12'($urandom_range(0, 4095));
      memQ[i] = 12'($urandom_range(0, 4095));
    end
  endtask

  task automatic run_job(input bit byp, input bit md, input int kf, input int n,
                         input int glitch_at, input int alo, input int ahi,
                         output int done_cyc);
    int keff, afw, nc;
    keff = byp ? 0 : ((kf > 4) ? 4 : kf);
    model(n, keff);
    gotI.delete(); gotQ.delete(); gotA.delete();
    config_reg = '0;
    config_reg[0] = byp;
    config_reg[1] = md;
    config_reg[39:32] = kf[7:0];
    config_reg[95:64] = n;
    Empty_i = 1'b0; Afull_i = 1'b0;
    start = 1'b1;
    done_cyc = -1; afw = 0;
    for (int c = 1; c <= 4*n + 60 && done_cyc < 0; c++) begin
      @(negedge clk);
      if (wem || wef) begin
        gotA.push_back(int'(wa));
        gotI.push_back(int'(idec));
        gotQ.push_back(int'(qdec));
        chk("we_route", wef, md);
        if (Afull_i) afw++;
      end
      if (!md) chk("ren_in_mem_mode", ren, 0);
      if (md && Afull_i) chk("ren_while_afull", ren, 0);
      if (st[1] && md) chk("stop_afull", st[3], Afull_i);
      if (st[1] && md) chk("stop_empty", st[2], Empty_i);
      if (c == 2 && n > 0) begin
        chk("busy", st[1], 1);
        chk("mode_bit", st[4], md);
        chk("bypass_bit", st[5], byp);
      end
      if (st[0]) begin
        done_cyc = c;
        chk("done_not_busy", st[1], 0);
      end
      // drive next cycle's inputs
      start = (c == glitch_at);
      if (c == glitch_at) config_reg = {$urandom, $urandom, $urandom, $urandom};
      nc = c + 1;
      Empty_i = md && ((nc % 2 == 1) ^ ($urandom_range(0, 3) == 0));
      Afull_i = md && (nc >= alo) && (nc < ahi);
    end
    start = 1'b0; Empty_i = 1'b0; Afull_i = 1'b0;
    chk("done_seen", done_cyc >= 0, 1);
    if (done_cyc >= 0) begin
      @(negedge clk);
      chk("done_one_cycle", st[0], 0);
    end
    chk("n_writes", gotI.size(), expI.size());
    for (int i = 0; i < gotI.size() && i < expI.size(); i++) begin
      chk("wr_addr", gotA[i], i);
      chk("wr_I", gotI[i], expI[i]);
      chk("wr_Q", gotQ[i], expQ[i]);
    end
    if (ahi > alo) chk("writes_during_afull_le2", afw <= 2, 1);
  endtask

  int dc;

  initial begin
    for (int i = 0; i < 256; i++) begin memI[i] = '0; memQ[i] = '0; end
    // reset state
    @(negedge clk); @(negedge clk);
    chk("rst_status", st, 0);
    chk("rst_raddr", ra, 0);
    chk("rst_waddr", wa, 0);
    chk("rst_I", idec, 0);
    chk("rst_en", {wem, wef, ren}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // directed: k=2, I=1..8, Q=-1..-8
    for (int i = 0; i < 8; i++) begin memI[i] = 12'(i + 1); memQ[i] = 12'(-(i + 1)); end
    run_job(0, 0, 2, 8, 0, 0, 0, dc);
    chk("t1_latency", dc, 11);
    if (gotI.size() >= 2) begin
      chk("t1_I0", gotI[0], 3);  chk("t1_Q0", gotQ[0], -2);
      chk("t1_I1", gotI[1], 7);  chk("t1_Q1", gotQ[1], -6);
    end

    // rounding at k=1
    memI[0] = -12'sd1; memI[1] = -12'sd2; memI[2] = 12'sd2047; memI[3] = 12'sd2047;
    for (int i = 0; i < 4; i++) memQ[i] = 12'($urandom_range(0, 4095));
    run_job(0, 0, 1, 4, 0, 0, 0, dc);
    if (gotI.size() >= 2) begin
      chk("round_neg", gotI[0], -1);
      chk("round_max", gotI[1], 2047);
    end

    // partial trailing block dropped
    load_rand(10);
    run_job(0, 0, 2, 10, 0, 0, 0, dc);
    chk("partial_latency", dc, 13);

    // ilen = 0
    run_job(0, 0, 2, 0, 0, 0, 0, dc);
    chk("ilen0_latency", dc, 1);

    // k field above max clamps to 4
    load_rand(37);
    run_job(0, 0, 9, 37, 0, 0, 0, dc);

    // bypass with k field 3: pass-through
    load_rand(4);
    run_job(1, 0, 3, 4, 0, 0, 0, dc);
    for (int i = 0; i < gotI.size() && i < 4; i++) chk("bypass_I", gotI[i], int'(memI[i]));

    // random memory-mode jobs
    for (int j = 0; j < 3; j++) begin
      int n, kf;
      n = $urandom_range(1, 60);
      kf = $urandom_range(0, 5);
      load_rand(n);
      run_job(0, 0, kf, n, 0, 0, 0, dc);
      chk("rand_latency", dc, n + 3);
    end

    // start pulsed mid-job with scrambled config: ignored
    load_rand(30);
    run_job(0, 0, 3, 30, 6, 0, 0, dc);
    chk("glitch_latency", dc, 33);

    // stream mode, Empty toggling, Afull window
    load_rand(40);
    run_job(0, 1, 2, 40, 0, 10, 30, dc);
    load_rand(25);
    run_job(0, 1, 1, 25, 0, 0, 0, dc);

    // reset mid-job
    load_rand(50);
    config_reg = '0;
    config_reg[39:32] = 8'd2;
    config_reg[95:64] = 50;
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_raddr", ra, 7);
    rstn = 1'b0;
    #1;
    chk("abort_status", st, 0);
    chk("abort_raddr", ra, 0);
    chk("abort_waddr", wa, 0);
    chk("abort_IQ", {idec, qdec}, 0);
    chk("abort_en", {wem, wef, ren}, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_no_done", st[0], 0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // recovery after abort
    load_rand(6);
    run_job(0, 0, 1, 6, 0, 0, 0, dc);
    chk("recover_latency", dc, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
